bcd_timer_cnt: RTL and testbench
================================

Name: bcd_timer_cnt

Overview:
Parametrised multi-digit BCD up/down counter. It is the next generation of the single-decade down counter used for irrigation timing.
- Adds: digit count, parallel load, count enable, direction select, saturate-or-wrap mode and terminal-count flags.
- Sits between the configuration logic, which loads the watering duration, and the valve controller, which consumes Zero/Tc to close the valve.

Parameters:
DIGITS, 2, number of BCD decades (1..8); count range 0 .. 10^DIGITS-1
WRAP, 0, 0 = hold at terminal value; 1 = wrap around (0 -> all-9 down, all-9 -> 0 up)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  synchronous reset, active-high
En  input  1  count enable; one step per cycle while high
Up  input  1  direction: 1 = increment, 0 = decrement
Load  input  1  parallel load strobe
LoadVal  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
Q  output  4*DIGITS  current BCD count, digit 0 in bits [3:0]
Zero  output  1  combinational: Q == all digits 0
Max  output  1  combinational: Q == all digits 9
Tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst). Priority each edge: Rst > Load > En.
- Reset: Q = 0, Tc = 0, so Zero = 1 and Max = 0 (Max = 0 for all DIGITS ≥ 1). Rst mid-count abandons the count immediately, with no residual Tc.
- Load: Q <= LoadVal on the next edge and Tc = 0 that cycle.
  - Any LoadVal digit > 9 is clamped to 9 per digit, e.g. 0xAF -> 0x99.
  - Load with En high: load wins and no count step occurs.
- Count, En=1 and Load=0: one step per edge.
  - Down: digit 0 decrements. A digit at 0 borrows, becomes 9 and decrements the next digit. The borrow ripples combinationally through all digits within a single cycle.
  - Up: digit 0 increments. A digit at 9 carries and becomes 0. Ripple as above.
- Terminal value: 0 when Up=0; all-9 when Up=1.
  - At terminal with En=1 and WRAP=0: Q holds.
  - At terminal with En=1 and WRAP=1: Q wraps (00 -> 99 down, 99 -> 00 up for DIGITS=2).
- Tc: high for exactly one cycle, in the cycle Q first shows the terminal value as the result of a count step.
  - Not asserted on a load to the terminal value or on reset.
  - Not re-asserted while Q holds at terminal (WRAP=0).
  - With WRAP=1 it pulses on each arrival at the terminal value.
- En=0: Q and flags hold; Tc = 0.
- Up may change on any cycle; the new direction applies at the next enabled edge.
- Q never holds a non-BCD digit: it is guaranteed by the load clamp and the digit arithmetic.
- Latency: Q updates one edge after the controlling input. Zero/Max follow Q combinationally.

Decomposition:
- Shared package: BCD_W = 4, BCD_MAX = 4'd9, BCD_MIN = 4'd0, and a function clamping a nibble to 0..9.
- Sub-module bcd_digit: one decade.
  - Inputs: Clk, Rst, load enable, load nibble, step-in, Up.
  - Outputs: digit value, step-out (borrow/carry when the digit is at 0/9 and step-in is high), is-terminal flag.
- The top generates DIGITS instances and chains step-out to the next step-in.
- The top computes the hold condition for WRAP=0, and the Zero, Max and Tc logic.

Test Plan:
- Rst for 1 cycle, DIGITS=2 -> Q=0x00, Zero=1, Max=0, Tc=0; Rst asserted at Q=0x13 mid-count -> next edge Q=0x00, Tc=0.
- WRAP=0, Load 0x25, then En=1 Up=0 -> Q 0x24, 0x23 ... 0x20, 0x19 (borrow) ... reaches 0x00 on the 25th enabled edge with Tc=1 for that cycle only; further En keeps Q=0x00 and Tc=0.
- WRAP=1, Load 0x01, En=1 Up=0 -> 0x00 with Tc pulse, then 0x99, 0x98; Up=1 from 0x98 -> 0x99 with Tc pulse, then 0x00.
- Load 0xAF -> Q=0x99, Max=1, Tc=0; Load 0x00 -> Zero=1 and no Tc.
- Load=1 and En=1 together with LoadVal=0x50 from Q=0x10 -> Q=0x50, no decrement; En=0 for 3 cycles -> Q stays 0x50.
- DIGITS=3: Load 0x100, one down step -> 0x099 (two-level borrow in one cycle); Up from 0x999 with WRAP=0 -> holds 0x999, Tc only on the arrival edge.

Source files
------------

// File: rtl/bcd_timer_cnt_pkg.sv
// Shared BCD constants and the nibble clamp used by the timer counter and its decades.
package bcd_timer_cnt_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    // Any nibble above 9 saturates to 9 so Q never holds a non-BCD digit.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_timer_cnt_digit.sv
// One BCD decade: load, increment/decrement on step_in, ripple carry/borrow out.
module bcd_digit
    import bcd_timer_cnt_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             step_in,
    input  logic             Up,
    output logic [BCD_W-1:0] q,
    output logic             step_out_c,
    output logic             is_term_c
);

    // Terminal is 9 when counting up, 0 when counting down.
    assign is_term_c  = Up ? (q == BCD_MAX) : (q == BCD_MIN);
    assign step_out_c = step_in & is_term_c;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= bcd_clamp(ld_val);
        end else if (step_in) begin
            if (Up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_timer_cnt.sv
// Multi-decade BCD up/down timer counter with load, hold-or-wrap at terminal and Tc pulse.
module bcd_timer_cnt
    import bcd_timer_cnt_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      En,
    input  logic                      Up,
    input  logic                      Load,
    input  logic [BCD_W*DIGITS-1:0]   LoadVal,
    output logic [BCD_W*DIGITS-1:0]   Q,
    output logic                      Zero,
    output logic                      Max,
    output logic                      Tc
);

    logic [DIGITS:0]   step;
    logic [DIGITS-1:0] is_term;
    logic              hold_c;
    logic              hi_term_c;
    logic              pre_term_c;
    logic              carry_unused;

    // Without wrap, a counter already at its terminal value stops stepping.
    assign hold_c       = ~WRAP & (&is_term);
    assign step[0]      = En & ~Load & ~hold_c;
    assign carry_unused = step[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .Clk        (Clk),
            .Rst        (Rst),
            .ld         (Load),
            .ld_val     (LoadVal[g*BCD_W +: BCD_W]),
            .step_in    (step[g]),
            .Up         (Up),
            .q          (Q[g*BCD_W +: BCD_W]),
            .step_out_c (step[g+1]),
            .is_term_c  (is_term[g])
        );
    end

    if (DIGITS > 1) begin : g_hi
        assign hi_term_c = &is_term[DIGITS-1:1];
    end else begin : g_one
        assign hi_term_c = 1'b1;
    end

    // One step away from terminal: upper decades already terminal, digit 0 at 8 (up) or 1 (down).
    assign pre_term_c = hi_term_c &
                        (Q[BCD_W-1:0] == (Up ? (BCD_MAX - 4'd1) : (BCD_MIN + 4'd1)));

    assign Zero = (Q == '0);

    always_comb begin
        Max = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (Q[i*BCD_W +: BCD_W] != BCD_MAX) begin
                Max = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Tc <= 1'b0;
        end else if (Load) begin
            Tc <= 1'b0;
        end else begin
            Tc <= step[0] & pre_term_c;
        end
    end

endmodule

// File: tb/tb_bcd_timer_cnt.sv
// Directed bench for bcd_timer_cnt: 2-digit hold, 2-digit wrap and 3-digit hold instances.
module tb_bcd_timer_cnt;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    logic        a_en = 0, a_up = 0, a_ld = 0;
    logic [7:0]  a_lv = '0;
    logic [7:0]  a_q;
    logic        a_zero, a_max, a_tc;

    logic        b_en = 0, b_up = 0, b_ld = 0;
    logic [7:0]  b_lv = '0;
    logic [7:0]  b_q;
    logic        b_zero, b_max, b_tc;

    logic        c_en = 0, c_up = 0, c_ld = 0;
    logic [11:0] c_lv = '0;
    logic [11:0] c_q;
    logic        c_zero, c_max, c_tc;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    bcd_timer_cnt #(.DIGITS(2), .WRAP(1'b0)) u_a (
        .Clk(Clk), .Rst(Rst), .En(a_en), .Up(a_up), .Load(a_ld), .LoadVal(a_lv),
        .Q(a_q), .Zero(a_zero), .Max(a_max), .Tc(a_tc));

    bcd_timer_cnt #(.DIGITS(2), .WRAP(1'b1)) u_b (
        .Clk(Clk), .Rst(Rst), .En(b_en), .Up(b_up), .Load(b_ld), .LoadVal(b_lv),
        .Q(b_q), .Zero(b_zero), .Max(b_max), .Tc(b_tc));

    bcd_timer_cnt #(.DIGITS(3), .WRAP(1'b0)) u_c (
        .Clk(Clk), .Rst(Rst), .En(c_en), .Up(c_up), .Load(c_ld), .LoadVal(c_lv),
        .Q(c_q), .Zero(c_zero), .Max(c_max), .Tc(c_tc));

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal integer to packed BCD, digit 0 in the low nibble.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    initial begin
        // Reset state on all instances
        step();
        chk("rst_q",    32'(a_q),    32'h00);
        chk("rst_zero", 32'(a_zero), 32'd1);
        chk("rst_max",  32'(a_max),  32'd0);
        chk("rst_tc",   32'(a_tc),   32'd0);
        chk("rst_q_b",  32'(b_q),    32'h00);
        chk("rst_q_c",  32'(c_q),    32'h000);
        chk("rst_max_c", 32'(c_max), 32'd0);
        Rst = 1'b0;

        // Hold mode: load 25 and count down to 0
        a_ld = 1; a_lv = 8'h25;
        step();
        chk("ld25_q",  32'(a_q),  32'h25);
        chk("ld25_tc", 32'(a_tc), 32'd0);
        a_ld = 0; a_en = 1; a_up = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            chk("dn_q",  32'(a_q),  to_bcd(25 - i));
            chk("dn_tc", 32'(a_tc), (i == 25) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold0_q",    32'(a_q),    32'h00);
            chk("hold0_tc",   32'(a_tc),   32'd0);
            chk("hold0_zero", 32'(a_zero), 32'd1);
        end

        // Reset mid-count abandons the count
        a_en = 0; a_ld = 1; a_lv = 8'h15;
        step();
        a_ld = 0; a_en = 1;
        step();
        step();
        chk("mid_q", 32'(a_q), 32'h13);
        Rst = 1;
        step();
        chk("midrst_q",  32'(a_q),  32'h00);
        chk("midrst_tc", 32'(a_tc), 32'd0);
        Rst = 0; a_en = 0;

        // Load clamp and load to terminal without Tc
        a_ld = 1; a_lv = 8'hAF;
        step();
        chk("clamp_q",   32'(a_q),   32'h99);
        chk("clamp_max", 32'(a_max), 32'd1);
        chk("clamp_tc",  32'(a_tc),  32'd0);
        a_lv = 8'h00;
        step();
        chk("ld0_zero", 32'(a_zero), 32'd1);
        chk("ld0_tc",   32'(a_tc),   32'd0);

        // Load beats En, then En low holds
        a_lv = 8'h10;
        step();
        a_en = 1; a_lv = 8'h50;
        step();
        chk("ldwin_q",  32'(a_q),  32'h50);
        chk("ldwin_tc", 32'(a_tc), 32'd0);
        a_ld = 0; a_en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_q",  32'(a_q),  32'h50);
            chk("en0_tc", 32'(a_tc), 32'd0);
        end

        // Wrap mode: down through 0, then up through 99
        b_ld = 1; b_lv = 8'h01;
        step();
        b_ld = 0; b_en = 1; b_up = 0;
        step();
        chk("w_q0",  32'(b_q),  32'h00);
        chk("w_tc0", 32'(b_tc), 32'd1);
        step();
        chk("w_q99",  32'(b_q),  32'h99);
        chk("w_tc99", 32'(b_tc), 32'd0);
        step();
        chk("w_q98", 32'(b_q), 32'h98);
        b_up = 1;
        step();
        chk("w_up99",    32'(b_q),   32'h99);
        chk("w_up99_tc", 32'(b_tc),  32'd1);
        chk("w_up99_mx", 32'(b_max), 32'd1);
        step();
        chk("w_up00",    32'(b_q),    32'h00);
        chk("w_up00_tc", 32'(b_tc),   32'd0);
        chk("w_up00_z",  32'(b_zero), 32'd1);
        step();
        chk("w_up01", 32'(b_q), 32'h01);
        b_en = 0;
        step();
        chk("w_en0_q",  32'(b_q),  32'h01);
        chk("w_en0_tc", 32'(b_tc), 32'd0);

        // Three decades: two-level borrow, then hold at 999
        c_ld = 1; c_lv = 12'h100;
        step();
        c_ld = 0; c_en = 1; c_up = 0;
        step();
        chk("c_borrow", 32'(c_q),  32'h099);
        chk("c_btc",    32'(c_tc), 32'd0);
        c_en = 0; c_ld = 1; c_lv = 12'h998;
        step();
        c_ld = 0; c_en = 1; c_up = 1;
        step();
        chk("c_up999",  32'(c_q),   32'h999);
        chk("c_up_tc",  32'(c_tc),  32'd1);
        chk("c_up_max", 32'(c_max), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("c_hold_q",  32'(c_q),  32'h999);
            chk("c_hold_tc", 32'(c_tc), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
